hazard_ctrl: RTL and testbench

- Pipeline hazard and sequencing controller for the 5-stage RV32 core.
- Drives the stall/flush controls of the IF/ID and ID/EX pipeline registers: load-use bubbles, taken-branch flushes, and multi-cycle holds of the ID/EX register while a multiply/divide op occupies EX.
- Sits beside the decode stage; consumes ID source registers and EX-stage status, and feeds enables/clears to PC, IF/ID and ID/EX.

---
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: groups the decode/execute status seen by the hazard
// controller and the stall/flush controls it returns to the pipeline.
//
// Signals:
//   RS1D, RS2D   [4:0]       rs1/rs2 of the instruction in ID
//   RDE          [4:0]       rd of the instruction in EX
//   MemReadE                 EX instruction is a load
//   PCSrcE                   taken branch/jump resolved in EX
//   MduOpE                   EX instruction is a multi-cycle MDU op
//   StallF/StallD/StallE     hold PC, IF/ID, ID/EX
//   FlushD/FlushE            clear IF/ID, ID/EX to NOP
//   busy                     controller is holding for an MDU op
//   stall_cnt    [CNT_W-1:0] count of StallD cycles (0 unless the counter is built)
//
// Modports: master = pipeline side (drives status), slave = hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       RS1D;
    logic [4:0]       RS2D;
    logic [4:0]       RDE;
    logic             MemReadE;
    logic             PCSrcE;
    logic             MduOpE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushD;
    logic             FlushE;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output RS1D, RS2D, RDE, MemReadE, PCSrcE, MduOpE,
        input  StallF, StallD, StallE, FlushD, FlushE, busy, stall_cnt
    );

    modport slave (
        input  RS1D, RS2D, RDE, MemReadE, PCSrcE, MduOpE,
        output StallF, StallD, StallE, FlushD, FlushE, busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller for the 5-stage
// RV32 core. Produces load-use bubbles, taken-branch flushes and multi-cycle
// ID/EX holds while an MDU op occupies EX.
//
// Ports:
//   clk  core clock, rising edge
//   rst  synchronous reset, active-high; forces all controls to 0
//   hz   hazard_ctrl_if.slave (ID/EX status in, stall/flush controls out)
//
// Parameters:
//   MDU_LAT  total cycles an MDU op occupies EX (2..16)
//   CNT_W    width of the stall performance counter
//
// Build option: define HAZARD_PERF_CNT_EN to build the saturating StallD
// cycle counter on hz.stall_cnt; otherwise stall_cnt is tied to 0.
module hazard_ctrl #(
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    hazard_ctrl_if.slave hz
);

    typedef enum logic {
        S_RUN,
        S_MDU
    } state_t;

    // The RUN cycle that spots the op already holds ID/EX, so MDU state
    // only has to cover the remaining MDU_LAT-2 hold cycles.
    localparam int unsigned MDU_CYC  = MDU_LAT - 2;
    localparam logic [3:0]  CNT_LOAD = (MDU_CYC == 0) ? 4'd0 : 4'(MDU_CYC - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mask_q, mask_d;

    logic lu;
    logic stall_f, stall_d, stall_e, flush_d, flush_e, busy;

    assign lu = hz.MemReadE && (hz.RDE != 5'd0) &&
                ((hz.RDE == hz.RS1D) || (hz.RDE == hz.RS2D));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        busy    = 1'b0;

        case (state_q)
            S_RUN: begin
                // The release cycle is the only RUN cycle that sees the mask.
                mask_d = 1'b0;
                if (hz.PCSrcE) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (hz.MduOpE && !mask_q) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    if (MDU_CYC == 0) begin
                        // Two-cycle op: this one hold is all it needs.
                        mask_d = 1'b1;
                    end else begin
                        state_d = S_MDU;
                        cnt_d   = CNT_LOAD;
                    end
                end else if (lu) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            S_MDU: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                busy    = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = S_RUN;
                    mask_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        if (rst) begin
            stall_f = 1'b0;
            stall_d = 1'b0;
            stall_e = 1'b0;
            flush_d = 1'b0;
            flush_e = 1'b0;
            busy    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            mask_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

    assign hz.StallF = stall_f;
    assign hz.StallD = stall_d;
    assign hz.StallE = stall_e;
    assign hz.FlushD = flush_d;
    assign hz.FlushE = flush_e;
    assign hz.busy   = busy;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // stall_d is already 0 during reset, so only StallD cycles out of reset count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_d && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
`else
    assign hz.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl. Directed sequences
// covering load-use, x0 loads, branch priority, MDU holds, reset mid-hold and
// counter saturation, followed by randomized traffic. Expected values come
// from a cycle model that tracks how many hold cycles an MDU op still owes.
module tb_hazard_ctrl;

    localparam int unsigned MDU_LAT = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    hazard_ctrl #(
        .MDU_LAT(MDU_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Model state: MDU hold cycles still owed after the trigger cycle,
    // whether the current cycle is the op's release cycle, StallD count.
    int unsigned m_hold_rem = 0;
    bit          m_release  = 1'b0;
    int unsigned m_cnt      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // One clock cycle: drive inputs, compare outputs mid-cycle, advance model.
    // Control vector order: {StallF, StallD, StallE, FlushD, FlushE, busy}.
    task automatic step(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input bit mr, input bit pc, input bit mdu,
                        input string tag);
        logic [5:0] exp_ctl;
        bit lu;
        bit trig;
        rst         = r;
        hz.RS1D     = rs1;
        hz.RS2D     = rs2;
        hz.RDE      = rd;
        hz.MemReadE = mr;
        hz.PCSrcE   = pc;
        hz.MduOpE   = mdu;
        #2;
        lu   = mr && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
        trig = 1'b0;
        if (r)                     exp_ctl = 6'b000000;
        else if (m_hold_rem > 0)   exp_ctl = 6'b111001;
        else if (pc)               exp_ctl = 6'b000110;
        else if (mdu && !m_release) begin
            exp_ctl = 6'b111000;
            trig    = 1'b1;
        end
        else if (lu)               exp_ctl = 6'b110010;
        else                       exp_ctl = 6'b000000;

        check({tag, ".ctl"}, {26'd0, hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.busy},
              {26'd0, exp_ctl});
        check({tag, ".cnt"}, 32'(hz.stall_cnt), 32'(m_cnt));

        @(posedge clk);
        if (r) begin
            m_hold_rem = 0;
            m_release  = 1'b0;
            m_cnt      = 0;
        end else begin
`ifdef HAZARD_PERF_CNT_EN
            if (exp_ctl[4] && m_cnt < CNT_MAX) m_cnt++;
`endif
            if (m_hold_rem > 0) begin
                m_hold_rem--;
                m_release = (m_hold_rem == 0);
            end else begin
                m_release = 1'b0;
                if (trig) begin
                    m_hold_rem = MDU_LAT - 2;
                    m_release  = (m_hold_rem == 0);
                end
            end
        end
        #1;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        rst         = 1'b1;
        hz.RS1D     = '0;
        hz.RS2D     = '0;
        hz.RDE      = '0;
        hz.MemReadE = 1'b0;
        hz.PCSrcE   = 1'b0;
        hz.MduOpE   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset forces every control low even with all triggers asserted.
        step(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, "rst_all");

        // Load-use bubble on rs1, then x0 load.
        step(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, "lu_rs1");
        idle("after_lu");
        step(1'b0, 5'd7, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, "lu_rs2");
        step(1'b0, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, "x0_load");

        // Branch beats MDU and load-use.
        step(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, "br_prio");
        idle("after_br");

        // Single MDU op held MDU_LAT cycles in EX.
        for (int i = 0; i < int'(MDU_LAT); i++)
            step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, "mdu1");
        idle("after_mdu1");

        // Two MDU ops back to back.
        for (int i = 0; i < 2 * int'(MDU_LAT); i++)
            step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, "mdu2");
        idle("after_mdu2");

        // Reset during the hold.
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, "mdu_rst0");
        step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, "mdu_rst1");
        idle("post_rst0");
        idle("post_rst1");

        // Long run of bubbles drives the counter into saturation.
        for (int i = 0; i < 20; i++)
            step(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, "sat");
        idle("sat_end");

        // Randomized traffic; an MDU op stays in EX while it is still held.
        for (int i = 0; i < 400; i++) begin
            bit r, pc, mdu, mr;
            r   = ($urandom_range(0, 99) < 2);
            pc  = ($urandom_range(0, 99) < 15);
            mr  = ($urandom_range(0, 99) < 40);
            if (m_hold_rem > 0 || m_release) mdu = 1'b1;
            else mdu = ($urandom_range(0, 99) < 20);
            step(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), mr, pc, mdu, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
